// File: rtl/led_cmd_scheduler.sv
// led_cmd_scheduler
//   Two-requester round-robin front end for the LED decoder command port.
//   req0 is the fabric/MSS register path, req1 the debounced board switches.
//   Each accepted code is presented on inSwitch with valid held high for
//   HOLD_CYCLES cycles. An idle gap of the same length follows, so that
//   consecutive commands arrive at the decoder clean and well spaced.
//   A HOLD_CYCLES of 0 behaves as 1, so a pulse and a gap are never empty.
module led_cmd_scheduler #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_code,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_code,
  output logic       req1_ready,
  output logic [1:0] inSwitch,
  output logic       valid,
  output logic       busy,
  output logic       last_grant
);

  // Effective hold length: a zero setting is promoted to a single cycle.
  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;

  // The counter runs from HOLD_EFF-1 down to 0, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  // Registered state
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ptr_q;
  logic [1:0]       code_q;
  logic             valid_q;
  logic             busy_q;
  logic             last_grant_q;

  // Next-state values
  state_e           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ptr_d;
  logic [1:0]       code_d;
  logic             valid_d;
  logic             busy_d;
  logic             last_grant_d;

  // Arbitration results
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic             grant_idx_s;
  logic [1:0]       grant_code_s;

  // Readies are offered only in IDLE. When both requesters are valid,
  // ptr decides who wins. A lone requester wins regardless of ptr.
  always_comb begin
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        if (ptr_q) begin
          ready1_s = 1'b1;
        end else begin
          ready0_s = 1'b1;
        end
      end else if (req0_valid) begin
        ready0_s = 1'b1;
      end else if (req1_valid) begin
        ready1_s = 1'b1;
      end else begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
      end
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  // Handshake completion and the identity and code of the winner.
  always_comb begin
    accept_s     = (req0_valid & ready0_s) | (req1_valid & ready1_s);
    grant_idx_s  = req1_valid & ready1_s;
    if (grant_idx_s) begin
      grant_code_s = req1_code;
    end else begin
      grant_code_s = req0_code;
    end
  end

  // Next-state logic for IDLE -> DRIVE -> GAP -> IDLE. valid and busy are
  // derived from the next state, so they are registered together with it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    code_d       = code_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_DRIVE;
          cnt_d        = CNT_RELOAD;
          code_d       = grant_code_s;
          last_grant_d = grant_idx_s;
          ptr_d        = ~grant_idx_s;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_GAP;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        // inSwitch keeps the last code during the gap.
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    valid_d = (state_d == ST_DRIVE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers. Reset clears everything asynchronously,
  // so an in-flight command is dropped immediately and is not resumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      ptr_q        <= 1'b0;
      code_q       <= 2'b00;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign inSwitch   = code_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Testbench for led_cmd_scheduler. The directed stimulus pushes the
// hand-computed grant (code, requester) into a scoreboard queue. A monitor
// pops one entry at each valid pulse and also checks the pulse length, the
// gap length and the spacing between pulses. A second instance built with
// HOLD_CYCLES=0 is checked directly.
module tb_led_cmd_scheduler;

  localparam int H = 10;

  typedef struct packed {
    logic [1:0] code;
    logic       grant;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req0_valid = 1'b0;
  logic [1:0] req0_code  = 2'b00;
  logic       req1_valid = 1'b0;
  logic [1:0] req1_code  = 2'b00;
  logic       req0_ready, req1_ready, valid, busy, last_grant;
  logic [1:0] inSwitch;

  logic       z_req0_valid = 1'b0;
  logic [1:0] z_req0_code  = 2'b00;
  logic       z_req1_valid = 1'b0;
  logic [1:0] z_req1_code  = 2'b00;
  logic       z_req0_ready, z_req1_ready, z_valid, z_busy, z_last_grant;
  logic [1:0] z_inSwitch;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  logic mon_en     = 1'b1;
  logic spacing_on = 1'b0;
  logic in_gap     = 1'b0;

  led_cmd_scheduler #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
    .inSwitch(inSwitch), .valid(valid), .busy(busy), .last_grant(last_grant)
  );

  led_cmd_scheduler #(.HOLD_CYCLES(0), .CNT_W(16)) dut_z (
    .clk(clk), .rst(rst),
    .req0_valid(z_req0_valid), .req0_code(z_req0_code), .req0_ready(z_req0_ready),
    .req1_valid(z_req1_valid), .req1_code(z_req1_code), .req1_ready(z_req1_ready),
    .inSwitch(z_inSwitch), .valid(z_valid), .busy(z_busy), .last_grant(z_last_grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  initial begin : monitor
    logic       prev_v;
    logic [1:0] cur_code;
    int         plen, glen, last_start;
    logic       have_start;
    exp_t       e;
    prev_v = 1'b0; cur_code = 2'b00; plen = 0; glen = 0;
    last_start = 0; have_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_v = 1'b0; in_gap = 1'b0; have_start = 1'b0;
      end else begin
        if (valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_pulse: got code %0d with no expected entry", inSwitch);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_code", 32'(inSwitch), 32'(e.code));
            chk("pulse_grant", 32'(last_grant), 32'(e.grant));
            chk("pulse_busy", 32'(busy), 32'd1);
            cur_code = e.code;
          end
          plen = 1;
          if (spacing_on && have_start) chk("pulse_spacing", 32'(cyc - last_start), 32'(2*H+1));
          last_start = cyc;
          have_start = spacing_on;
        end else if (valid) begin
          plen++;
        end else if (prev_v) begin
          chk("pulse_len", 32'(plen), 32'(H));
          chk("gap_code", 32'(inSwitch), 32'(cur_code));
          in_gap = busy;
          glen = busy ? 1 : 0;
        end else if (in_gap) begin
          if (busy) glen++;
          else begin
            chk("gap_len", 32'(glen), 32'(H));
            in_gap = 1'b0;
          end
        end
        prev_v = valid;
      end
    end
  end

  // Wait, with a bound, until every expected pulse was seen and the DUT is idle.
  task automatic drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !in_gap) break;
    end
    chk({name, "_drain_timeout"}, 32'(k < 200), 32'd1);
    @(negedge clk);
  endtask

  // Issue one command and hold it until accepted. Returns on the falling edge
  // after the accept edge, with the request withdrawn.
  task automatic send(input logic idx, input logic [1:0] code, input string name);
    int k;
    exp_q.push_back('{code: code, grant: idx});
    if (idx) begin req1_valid = 1'b1; req1_code = code; end
    else     begin req0_valid = 1'b1; req0_code = code; end
    for (k = 0; k < 100; k++) begin
      #1;
      if ((idx ? req1_ready : req0_ready) === 1'b1) break;
      @(negedge clk);
    end
    chk({name, "_ready_timeout"}, 32'(k < 100), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (idx) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  initial begin : stim
    int   n_acc, k;
    logic bad;

    // 1. reset state, then a single req0 command
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_inSwitch", 32'(inSwitch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    exp_q.push_back('{code: 2'b01, grant: 1'b0});
    req0_valid = 1'b1; req0_code = 2'b01;
    #1;
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_ready0_one_cycle", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    drain("t1");

    // 2. both requesters continuously valid from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{code: 2'b10, grant: 1'b0});
    exp_q.push_back('{code: 2'b11, grant: 1'b1});
    exp_q.push_back('{code: 2'b10, grant: 1'b0});
    exp_q.push_back('{code: 2'b11, grant: 1'b1});
    spacing_on = 1'b1;
    req0_valid = 1'b1; req0_code = 2'b10;
    req1_valid = 1'b1; req1_code = 2'b11;
    n_acc = 0;
    for (k = 0; k < 200 && n_acc < 4; k++) begin
      #1;
      if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) n_acc++;
      @(negedge clk);
    end
    chk("t2_accept_count", 32'(n_acc), 32'd4);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t2");
    spacing_on = 1'b0;

    // 3. only req1, twice in a row
    send(1'b1, 2'b11, "t3a");
    drain("t3a");
    send(1'b1, 2'b00, "t3b");
    drain("t3b");

    // 4. req0 raised while a req1 command is being driven
    send(1'b1, 2'b01, "t4");
    repeat (3) @(negedge clk);
    exp_q.push_back('{code: 2'b10, grant: 1'b0});
    req0_valid = 1'b1; req0_code = 2'b10;
    bad = 1'b0;
    for (k = 0; k < 100; k++) begin
      #1;
      if (!busy) break;
      if (req0_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("t4_ready_blocked", 32'(bad), 32'd0);
    chk("t4_ready_first_idle", 32'(req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    drain("t4");

    // 5. reset in the middle of DRIVE with a further req0 pending
    mon_en = 1'b0;
    req0_valid = 1'b1; req0_code = 2'b11;
    #1;
    chk("t5_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_code = 2'b10;
    repeat (4) @(negedge clk);
    chk("t5_valid_in_drive", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_inSwitch", 32'(inSwitch), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready_after_rst", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("t5_valid_after_rst", 32'(valid), 32'd1);
    chk("t5_code_after_rst", 32'(inSwitch), 32'd2);
    chk("t5_grant_after_rst", 32'(last_grant), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    for (k = 0; k < 100 && busy; k++) @(negedge clk);
    chk("t5_idle_timeout", 32'(k < 100), 32'd1);

    // 6. HOLD_CYCLES=0 instance: one-cycle pulse, one-cycle gap
    @(negedge clk);
    z_req1_valid = 1'b1; z_req1_code = 2'b10;
    #1;
    chk("t6_ready1", 32'(z_req1_ready), 32'd1);
    @(negedge clk);
    chk("t6_valid_hi", 32'(z_valid), 32'd1);
    chk("t6_code", 32'(z_inSwitch), 32'd2);
    chk("t6_busy_drive", 32'(z_busy), 32'd1);
    chk("t6_grant", 32'(z_last_grant), 32'd1);
    z_req1_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid_gap", 32'(z_valid), 32'd0);
    chk("t6_busy_gap", 32'(z_busy), 32'd1);
    chk("t6_code_gap", 32'(z_inSwitch), 32'd2);
    @(negedge clk);
    chk("t6_busy_idle", 32'(z_busy), 32'd0);
    chk("t6_valid_idle", 32'(z_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
